// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU load/store, DMA and memory-side signals of the data-memory arbiter
// slave is the arbiter's view, master is the surrounding CPU/DMA/memory environment
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_err;
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_done;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_ready,
      output cpu_stall, cpu_rdata, cpu_err, dma_gnt, dma_done, dma_rdata, dma_err, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_ready,
      input  cpu_stall, cpu_rdata, cpu_err, dma_gnt, dma_done, dma_rdata, dma_err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM-stage CPU and a DMA/debug master.
// DMEM_ARB_RR_EN selects round-robin on simultaneous requests; otherwise the CPU always wins.
module dmem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CPU_XFER = 2'd1;
   localparam logic [1:0] DMA_XFER = 2'd2;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   logic [1:0]    state;
   logic [CW-1:0] wcnt;
   logic          cpu_req;
   logic          cpu_win;
   logic          dma_win;
   logic          xfer;
   logic          tmo;
   logic          fin;
   assign cpu_req = bus.cpu_rd | bus.cpu_wr;
`ifdef DMEM_ARB_RR_EN
   logic last_cpu;
   assign cpu_win = cpu_req & (~bus.dma_req | ~last_cpu);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         last_cpu <= 1'b0;
      else if (state == IDLE && (cpu_win || dma_win))
         last_cpu <= cpu_win;
`else
   assign cpu_win = cpu_req;
`endif
   assign dma_win = bus.dma_req & ~cpu_win;
   assign xfer    = state != IDLE;
   // a memory response in the same cycle as the limit still counts as a normal completion
   assign tmo     = xfer & ~bus.mem_ready & (wcnt == CW'(TIMEOUT));
   assign fin     = xfer & (bus.mem_ready | tmo);
   assign bus.mem_req   = xfer;
   assign bus.cpu_stall = cpu_req & ~((state == CPU_XFER) & fin);
   assign bus.dma_gnt   = rst_n & (state == IDLE) & dma_win;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         wcnt          <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.cpu_rdata <= '0;
         bus.cpu_err   <= 1'b0;
         bus.dma_rdata <= '0;
         bus.dma_done  <= 1'b0;
         bus.dma_err   <= 1'b0;
      end else begin
         bus.cpu_err  <= (state == CPU_XFER) & tmo;
         bus.dma_done <= (state == DMA_XFER) & fin;
         bus.dma_err  <= (state == DMA_XFER) & tmo;
         if (state == IDLE) begin
            wcnt <= '0;
            if (cpu_win || dma_win) begin
               state         <= cpu_win ? CPU_XFER : DMA_XFER;
               bus.mem_we    <= cpu_win ? bus.cpu_wr : bus.dma_we;
               bus.mem_addr  <= cpu_win ? bus.cpu_addr : bus.dma_addr;
               bus.mem_wdata <= cpu_win ? bus.cpu_wdata : bus.dma_wdata;
            end
         end else if (fin) begin
            state <= IDLE;
            if (state == CPU_XFER && (tmo || !bus.mem_we))
               bus.cpu_rdata <= tmo ? '0 : bus.mem_rdata;
            if (state == DMA_XFER && (tmo || !bus.mem_we))
               bus.dma_rdata <= tmo ? '0 : bus.mem_rdata;
         end else
            wcnt <= wcnt + 1'b1;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the arbiter (honours DMEM_ARB_RR_EN).
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 15;
   localparam int NEVER = 1000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_vec = 0;
   int n_err = 0;
   // model: owner 0 none, 1 cpu, 2 dma; cycles waited in the current transfer
   int m_own = 0;
   int m_wait = 0;
   logic m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
`ifdef DMEM_ARB_RR_EN
   bit m_last_cpu = 1'b0;
`endif
   logic [DW-1:0] e_crd = '0;
   logic [DW-1:0] e_drd = '0;
   bit e_cerr = 0, e_done = 0, e_derr = 0;
   int lat = 0;
   bit rand_lat = 0, spur = 0;
   logic [DW-1:0] rdval = '0;
   bit s_stall = 0, s_gnt = 0, s_req = 0, s_done = 0, s_err = 0, s_cerr = 0;
   int n_stall = 0, n_req = 0, n_gnt = 0, n_cerr = 0;
   logic [AW-1:0] r_addr = '0;
   logic r_we = 1'b0, r_derr = 1'b0;
   logic [DW-1:0] r_drd = '0;
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic mreset();
      m_own = 0; m_wait = 0; e_crd = '0; e_drd = '0; e_cerr = 0; e_done = 0; e_derr = 0;
`ifdef DMEM_ARB_RR_EN
      m_last_cpu = 0;
`endif
   endtask
   function automatic int pick();
      bit c = bus.cpu_rd | bus.cpu_wr;
`ifdef DMEM_ARB_RR_EN
      if (c && bus.dma_req) return m_last_cpu ? 2 : 1;
`endif
      return c ? 1 : (bus.dma_req ? 2 : 0);
   endfunction
   function automatic int new_lat();
      int k = $urandom_range(7);
      return k < 5 ? k : (k == 5 ? 14 : (k == 6 ? 15 : NEVER));
   endfunction
   // one clock: drive memory side, check outputs, advance the model; entered and left at negedge
   task automatic step();
      int w;
      bit tmo, fin;
      bus.mem_ready = rst_n && ((m_own != 0 && m_wait == lat) || (m_own == 0 && spur && $urandom_range(2) == 0));
      bus.mem_rdata = rdval;
      #1;
      w = pick();
      tmo = m_own != 0 && !bus.mem_ready && m_wait == TO;
      fin = m_own != 0 && (bus.mem_ready || tmo);
      chk("cpu_stall", bus.cpu_stall, (bus.cpu_rd | bus.cpu_wr) && !(m_own == 1 && fin));
      chk("mem_req", bus.mem_req, m_own != 0);
      if (m_own != 0) begin
         chk("mem_we", bus.mem_we, m_we);
         chk("mem_addr", bus.mem_addr, m_addr);
         chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("dma_gnt", bus.dma_gnt, rst_n && m_own == 0 && w == 2);
      chk("cpu_rdata", bus.cpu_rdata, e_crd);
      chk("cpu_err", bus.cpu_err, e_cerr);
      chk("dma_done", bus.dma_done, e_done);
      chk("dma_err", bus.dma_err, e_derr);
      chk("dma_rdata", bus.dma_rdata, e_drd);
      s_stall = bus.cpu_stall; s_gnt = bus.dma_gnt; s_req = bus.mem_req;
      s_done = bus.dma_done; s_err = bus.dma_err; s_cerr = bus.cpu_err;
      n_stall += int'(s_stall); n_req += int'(s_req); n_gnt += int'(s_gnt); n_cerr += int'(s_cerr);
      if (s_req) begin r_addr = bus.mem_addr; r_we = bus.mem_we; end
      if (s_done) begin r_derr = s_err; r_drd = bus.dma_rdata; end
      @(posedge clk);
      e_cerr = 0; e_done = 0; e_derr = 0;
      if (!rst_n) mreset();
      else if (m_own != 0) begin
         if (fin) begin
            if (m_own == 1) begin
               if (tmo || !m_we) e_crd = tmo ? '0 : bus.mem_rdata;
               e_cerr = tmo;
            end else begin
               if (tmo || !m_we) e_drd = tmo ? '0 : bus.mem_rdata;
               e_done = 1; e_derr = tmo;
            end
            m_own = 0;
         end else m_wait++;
      end else if (w != 0) begin
         m_own = w; m_wait = 0;
         m_we = w == 1 ? bus.cpu_wr : bus.dma_we;
         m_addr = w == 1 ? bus.cpu_addr : bus.dma_addr;
         m_wdata = w == 1 ? bus.cpu_wdata : bus.dma_wdata;
         if (rand_lat) lat = new_lat();
`ifdef DMEM_ARB_RR_EN
         m_last_cpu = w == 1;
`endif
      end
      @(negedge clk);
   endtask
   task automatic cpu_op(bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!s_stall) break;
      end
      chk("cpu_op_bound", s_stall, 0);
      bus.cpu_rd = 0; bus.cpu_wr = 0;
   endtask
   task automatic dma_op(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
      for (int i = 0; i < 40; i++) begin
         step();
         if (s_gnt) break;
      end
      chk("dma_gnt_bound", s_gnt, 1);
      bus.dma_req = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (s_done) break;
      end
      chk("dma_done_bound", s_done, 1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired: got no finish, expected finish");
      $fatal(1);
   end
   initial begin
      logic [AW-1:0] first;
      int gnt_c, k;
      bit seen;
      bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
      @(negedge clk);
      step(); step();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      rst_n = 1;
      step();
      // CPU write, ready on first transfer cycle
      n_stall = 0; n_req = 0; lat = 0;
      cpu_op(0, 1, 'h10, 'hDEADBEEF);
      step(); step();
      chk("w_stall_cycles", n_stall, 1);
      chk("w_req_cycles", n_req, 1);
      chk("w_addr", r_addr, 'h10);
      chk("w_we", r_we, 1);
      // CPU read with three wait cycles
      n_stall = 0; lat = 3; rdval = 'hDEADBEEF;
      cpu_op(1, 0, 'h10, '0);
      chk("r_stall_cycles", n_stall, 4);
      chk("r_rdata", bus.cpu_rdata, 'hDEADBEEF);
      rdval = 'h0BAD0BAD;
      // simultaneous CPU read and DMA read
      lat = 0; first = '0; seen = 0; gnt_c = -1;
      bus.cpu_rd = 1; bus.cpu_addr = 'h30; bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 'h40;
      for (int c = 0; c < 8; c++) begin
         step();
         if (s_req && !seen) begin first = r_addr; seen = 1; end
         if (s_gnt) begin gnt_c = c; bus.dma_req = 0; end
         if (!s_stall) bus.cpu_rd = 0;
      end
`ifdef DMEM_ARB_RR_EN
      chk("tie_first_addr", first, 'h40);
      chk("tie_gnt_cycle", gnt_c, 0);
`else
      chk("tie_first_addr", first, 'h30);
      chk("tie_gnt_cycle", gnt_c, 2);
`endif
      // DMA read, then DMA read that times out
      lat = 1; rdval = 'h12345678;
      dma_op(0, 'h20, '0);
      chk("dma_rdata_ok", bus.dma_rdata, 'h12345678);
      lat = NEVER; rdval = 'h5A5A5A5B; n_req = 0; n_gnt = 0;
      dma_op(0, 'h20, '0);
      chk("tmo_req_cycles", n_req, 16);
      chk("tmo_gnt_pulses", n_gnt, 1);
      chk("tmo_err_with_done", r_derr, 1);
      chk("tmo_dma_rdata", r_drd, 0);
      chk("tmo_idle", bus.mem_req, 0);
      // reset in the middle of a CPU transfer
      n_cerr = 0; lat = NEVER;
      bus.cpu_rd = 1; bus.cpu_addr = 'h10;
      step(); step();
      rst_n = 0;
      #1;
      chk("rst_drop_req", bus.mem_req, 0);
      chk("rst_stall", bus.cpu_stall, 1);
      mreset();
      @(negedge clk);
      step(); step();
      rst_n = 1; lat = 0; rdval = 'hCAFE0001;
      cpu_op(1, 0, 'h10, '0);
      step();
      chk("post_rst_rdata", bus.cpu_rdata, 'hCAFE0001);
      chk("post_rst_no_cerr", n_cerr, 0);
      // randomized traffic
      rand_lat = 1; spur = 1;
      for (int i = 0; i < 2500; i++) begin
         if (!s_stall) begin
            k = $urandom_range(4);
            bus.cpu_rd = k == 1 || k == 3; bus.cpu_wr = k == 2 || k == 3;
            bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
         end
         if (s_gnt || !bus.dma_req) begin
            bus.dma_req = $urandom_range(2) == 0; bus.dma_we = 1'($urandom_range(1));
            bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
         end
         rdval = $urandom;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- TIMEOUT, 15, maximum wait cycles for mem_ready.
REQ-002 The block SHALL have one clock, clk, and asynchronous active-low reset rst_n; ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cpu_rd, in, 1, MEM-stage load request.
- cpu_wr, in, 1, MEM-stage store request.
- cpu_addr, in, ADDR_W, load/store address (ALU result).
- cpu_wdata, in, DATA_W, store data.
- cpu_stall, out, 1, freeze pipeline.
- cpu_rdata, out, DATA_W, load data to MEM/WB.
- cpu_err, out, 1, CPU access timed out.
- dma_req, in, 1, DMA/debug request.
- dma_we, in, 1, DMA write enable.
- dma_addr, in, ADDR_W, DMA address.
- dma_wdata, in, DATA_W, DMA write data.
- dma_gnt, out, 1, request accepted pulse.
- dma_done, out, 1, access complete pulse.
- dma_rdata, out, DATA_W, DMA read data.
- dma_err, out, 1, DMA access timed out.
- mem_req, out, 1, memory access active.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_ready, in, 1, memory completion, single cycle.

Function
REQ-003 The block SHALL have a three-state FSM: IDLE, CPU_XFER, DMA_XFER.
REQ-004 In IDLE, on a clk edge with a pending request, it SHALL latch the winner's addr/wdata/we into mem_* and go to the matching XFER state; mem_req SHALL be high exactly while in an XFER state.
REQ-005 With cpu_rd and cpu_wr both high, it SHALL perform a write.
REQ-006 mem_addr/mem_wdata/mem_we SHALL stay stable while mem_req is high; new inputs SHALL be ignored.
REQ-007 In an XFER state, mem_ready high SHALL complete the access and return to IDLE on that edge. A new grant needs at least one IDLE cycle.
REQ-008 mem_ready in IDLE SHALL be ignored.
REQ-009 cpu_stall (combinational) SHALL equal (cpu_rd|cpu_wr) AND NOT (state==CPU_XFER AND (mem_ready OR timeout)).
- Minimum CPU access: 2 cycles, 1 stall cycle.
REQ-010 On CPU read completion, cpu_rdata SHALL load mem_rdata on the completing edge and hold until the next CPU read completion. CPU write completion SHALL leave cpu_rdata unchanged.
REQ-011 dma_gnt SHALL pulse for one cycle on the IDLE cycle in which DMA is granted. The requester may drop dma_req after that cycle.
REQ-012 dma_done SHALL pulse for one cycle after DMA completion. dma_rdata SHALL load mem_rdata on DMA read completion and hold.
REQ-013 A wait counter SHALL clear on entry to an XFER state and increment each XFER cycle without mem_ready.
REQ-014 Timeout SHALL be when the wait counter equals TIMEOUT. It SHALL end the access and return to IDLE.
REQ-015 On a CPU timeout, cpu_rdata SHALL be 0 and cpu_err SHALL pulse for one cycle. On a DMA timeout, dma_rdata SHALL be 0 and dma_err and dma_done SHALL pulse for one cycle.
REQ-016 Priority on simultaneous requests SHALL follow REQ-019. A lone requester SHALL always win.

Reset
REQ-017 rst_n low SHALL asynchronously force state IDLE and clear the wait counter and the last-grant flag.
REQ-018 During reset all outputs SHALL be 0, except cpu_stall, which follows REQ-009 and is therefore 0 in IDLE with no CPU request. An in-flight access SHALL be abandoned with no done or err pulse.

Configuration
REQ-019 Macro DMEM_ARB_RR_EN:
- Defined: round-robin. A 1-bit last-grant flag records the last winner, and simultaneous requests go to the other requester.
- Undefined: fixed priority, CPU always wins; no last-grant flag is implemented.

Verification
REQ-020 CPU write 0xDEADBEEF to 0x10, mem_ready on the 1st XFER cycle:
- mem_req high 1 cycle with mem_we=1, mem_addr=0x10.
- cpu_stall high 1 cycle.
REQ-021 CPU read 0x10, memory returns 0xDEADBEEF after 3 wait cycles: cpu_stall high 4 cycles, then cpu_rdata=0xDEADBEEF.
REQ-022 cpu_rd and dma_req rise together:
- Fixed priority: CPU served first, then dma_gnt after one IDLE cycle.
- DMEM_ARB_RR_EN, after a previous CPU grant: DMA served first.
REQ-023 DMA read at 0x20, mem_ready never asserted:
- Timeout after 15 wait cycles.
- dma_done and dma_err pulse together, dma_rdata=0, FSM back to IDLE.
REQ-024 rst_n pulled low mid-CPU_XFER: mem_req drops immediately, no cpu_err. After release, a CPU read at 0x10 completes normally.
